// File: rtl/oled_slave_pkg.sv
// Shared SSD1306 opcode constants, argument counts and parser types for the
// OLED slave and its serial receiver.
package oled_slave_pkg;

  typedef enum logic [1:0] {
    ST_OPCODE,
    ST_ARG,
    ST_SKIP
  } parser_state_e;

  localparam logic [7:0] OP_DISPLAY_OFF  = 8'hAE;
  localparam logic [7:0] OP_DISPLAY_ON   = 8'hAF;
  localparam logic [7:0] OP_SET_CONTRAST = 8'h81;
  localparam logic [7:0] OP_COL_ADDR     = 8'h21;
  localparam logic [7:0] OP_PAGE_ADDR    = 8'h22;
  localparam logic [7:0] OP_MEM_MODE     = 8'h20;
  localparam logic [7:0] OP_CLK_DIV      = 8'hD5;
  localparam logic [7:0] OP_MUX_RATIO    = 8'hA8;
  localparam logic [7:0] OP_DISP_OFFSET  = 8'hD3;
  localparam logic [7:0] OP_CHARGE_PUMP  = 8'h8D;
  localparam logic [7:0] OP_COM_PINS     = 8'hDA;
  localparam logic [7:0] OP_PRECHARGE    = 8'hD9;
  localparam logic [7:0] OP_VCOMH        = 8'hDB;

  localparam logic [1:0] ARGS_CONTRAST  = 2'd1;
  localparam logic [1:0] ARGS_COL_ADDR  = 2'd2;
  localparam logic [1:0] ARGS_PAGE_ADDR = 2'd2;
  localparam logic [1:0] ARGS_SKIP      = 2'd1;

  localparam logic [7:0] CONTRAST_DEFAULT = 8'h7F;

  typedef struct packed {
    logic [6:0] col_start;
    logic [6:0] col_end;
    logic [2:0] page_start;
    logic [2:0] page_end;
  } window_t;

  localparam window_t WINDOW_DEFAULT = '{col_start: 7'd0, col_end: 7'd127,
                                         page_start: 3'd0, page_end: 3'd7};

  // Opcodes whose arguments the block interprets; zero means not one of them.
  function automatic logic [1:0] arg_count(input logic [7:0] op);
    case (op)
      OP_SET_CONTRAST: arg_count = ARGS_CONTRAST;
      OP_COL_ADDR:     arg_count = ARGS_COL_ADDR;
      OP_PAGE_ADDR:    arg_count = ARGS_PAGE_ADDR;
      default:         arg_count = 2'd0;
    endcase
  endfunction

  function automatic logic is_skip_op(input logic [7:0] op);
    case (op)
      OP_MEM_MODE, OP_CLK_DIV, OP_MUX_RATIO, OP_DISP_OFFSET,
      OP_CHARGE_PUMP, OP_COM_PINS, OP_PRECHARGE, OP_VCOMH: is_skip_op = 1'b1;
      default: is_skip_op = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/oled_slave_if.sv
// SPI pin bundle from the host plus the framebuffer/status outputs of the slave.
interface oled_slave_if;
  logic       pin_din;
  logic       pin_clk;
  logic       pin_cs;
  logic       pin_dc;
  logic       pin_res;
  logic       fb_we;
  logic [2:0] fb_page;
  logic [6:0] fb_column;
  logic [7:0] fb_data;
  logic       display_on;
  logic [7:0] contrast;
  logic       byte_err;

  modport master (
    output pin_din, pin_clk, pin_cs, pin_dc, pin_res,
    input  fb_we, fb_page, fb_column, fb_data, display_on, contrast, byte_err
  );

  modport slave (
    input  pin_din, pin_clk, pin_cs, pin_dc, pin_res,
    output fb_we, fb_page, fb_column, fb_data, display_on, contrast, byte_err
  );
endinterface

// File: rtl/oled_spi_rx.sv
// SPI byte receiver: shifts MSB-first bits while cs is low and flags a byte,
// or an aborted partial byte, for one cycle.
module oled_spi_rx (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cs_n,
  input  logic       din,
  input  logic       dc,
  output logic [7:0] data_byte,
  output logic       is_data,
  output logic       valid,
  output logic       byte_err
);

  logic [2:0] bit_cnt;
  logic [7:0] shift_p0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt  <= 3'd0;
      valid    <= 1'b0;
      byte_err <= 1'b0;
      is_data  <= 1'b0;
    end else begin
      valid    <= 1'b0;
      byte_err <= 1'b0;
      if (!cs_n) begin
        if (bit_cnt == 3'd0) is_data <= dc;
        bit_cnt <= bit_cnt + 3'd1;
        valid   <= (bit_cnt == 3'd7);
      end else if (bit_cnt != 3'd0) begin
        bit_cnt  <= 3'd0;
        byte_err <= 1'b1;
      end
    end
  end

  // Byte stays stable for the valid cycle: the next shift happens one edge later.
  always_ff @(posedge clk) begin
    if (!cs_n) shift_p0 <= {shift_p0[6:0], din};
  end

  assign data_byte = shift_p0;

endmodule

// File: rtl/oled_slave.sv
// SSD1306-style SPI slave: decodes command bytes and turns data bytes into
// framebuffer writes with horizontal-mode address advance.
module oled_slave
  import oled_slave_pkg::*;
(
  input  logic         clk,
  input  logic         rst_n,
  oled_slave_if.slave  bus
);

  // The SPI clock is the system clock net; the pin is never sampled.
  logic unused_pin_clk;
  assign unused_pin_clk = bus.pin_clk;

  logic [7:0] rx_byte;
  logic       rx_is_data;
  logic       rx_vld_p0;
  logic       rx_err;

  oled_spi_rx u_rx (
    .clk      (clk),
    .rst_n    (rst_n),
    .cs_n     (bus.pin_cs),
    .din      (bus.pin_din),
    .dc       (bus.pin_dc),
    .data_byte(rx_byte),
    .is_data  (rx_is_data),
    .valid    (rx_vld_p0),
    .byte_err (rx_err)
  );

  logic cmd_vld;
  logic data_vld;
  assign cmd_vld  = rx_vld_p0 && !rx_is_data;
  assign data_vld = rx_vld_p0 &&  rx_is_data;

  parser_state_e state, state_nxt;
  logic [1:0]    args_left, args_left_nxt;
  logic [7:0]    cur_op, cur_op_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_OPCODE;
      args_left <= 2'd0;
      cur_op    <= 8'h00;
    end else begin
      state     <= state_nxt;
      args_left <= args_left_nxt;
      cur_op    <= cur_op_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    args_left_nxt = args_left;
    cur_op_nxt    = cur_op;
    if (!bus.pin_res) begin
      state_nxt     = ST_OPCODE;
      args_left_nxt = 2'd0;
    end else if (cmd_vld) begin
      case (state)
        ST_OPCODE: begin
          cur_op_nxt = rx_byte;
          if (arg_count(rx_byte) != 2'd0) begin
            state_nxt     = ST_ARG;
            args_left_nxt = arg_count(rx_byte);
          end else if (is_skip_op(rx_byte)) begin
            state_nxt     = ST_SKIP;
            args_left_nxt = ARGS_SKIP;
          end
        end
        default: begin
          // Argument bytes are never decoded as opcodes.
          args_left_nxt = args_left - 2'd1;
          if (args_left == 2'd1) state_nxt = ST_OPCODE;
        end
      endcase
    end
  end

  window_t    win;
  logic [6:0] col_ptr;
  logic [2:0] page_ptr;
  logic       display_on_q;
  logic [7:0] contrast_q;
  logic       fb_we_q;
  logic [2:0] fb_page_q;
  logic [6:0] fb_column_q;
  logic [7:0] fb_data_q;

  // Stage p1: register updates one cycle after byte completion.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win          <= WINDOW_DEFAULT;
      col_ptr      <= 7'd0;
      page_ptr     <= 3'd0;
      display_on_q <= 1'b0;
      contrast_q   <= CONTRAST_DEFAULT;
      fb_we_q      <= 1'b0;
      fb_page_q    <= 3'd0;
      fb_column_q  <= 7'd0;
      fb_data_q    <= 8'h00;
    end else if (!bus.pin_res) begin
      win          <= WINDOW_DEFAULT;
      col_ptr      <= 7'd0;
      page_ptr     <= 3'd0;
      display_on_q <= 1'b0;
      contrast_q   <= CONTRAST_DEFAULT;
      fb_we_q      <= 1'b0;
      fb_page_q    <= 3'd0;
      fb_column_q  <= 7'd0;
      fb_data_q    <= 8'h00;
    end else begin
      fb_we_q <= 1'b0;
      if (data_vld) begin
        fb_we_q     <= 1'b1;
        fb_page_q   <= page_ptr;
        fb_column_q <= col_ptr;
        fb_data_q   <= rx_byte;
        if (col_ptr == win.col_end) begin
          col_ptr  <= win.col_start;
          page_ptr <= (page_ptr == win.page_end) ? win.page_start : page_ptr + 3'd1;
        end else begin
          col_ptr <= col_ptr + 7'd1;
        end
      end
      if (cmd_vld && state == ST_OPCODE) begin
        if (rx_byte == OP_DISPLAY_ON)  display_on_q <= 1'b1;
        if (rx_byte == OP_DISPLAY_OFF) display_on_q <= 1'b0;
      end
      if (cmd_vld && state == ST_ARG) begin
        case (cur_op)
          OP_SET_CONTRAST: contrast_q <= rx_byte;
          OP_COL_ADDR: begin
            if (args_left == 2'd2) begin
              win.col_start <= rx_byte[6:0];
            end else begin
              win.col_end <= rx_byte[6:0];
              col_ptr     <= win.col_start;
            end
          end
          OP_PAGE_ADDR: begin
            if (args_left == 2'd2) begin
              win.page_start <= rx_byte[2:0];
            end else begin
              win.page_end <= rx_byte[2:0];
              page_ptr     <= win.page_start;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.fb_we      = fb_we_q;
  assign bus.fb_page    = fb_page_q;
  assign bus.fb_column  = fb_column_q;
  assign bus.fb_data    = fb_data_q;
  assign bus.display_on = display_on_q;
  assign bus.contrast   = contrast_q;
  assign bus.byte_err   = rx_err;

endmodule

// File: tb/tb_oled_slave.sv
// Directed bench for oled_slave: a byte-level model of the SSD1306 command set
// predicts every output cycle, with literal expectations for the key scenarios.
module tb_oled_slave;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  oled_slave_if bus();
  assign bus.pin_clk = clk;

  oled_slave dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int page;
    int col;
    int data;
  } wr_t;

  // Model state: whole-command view of the display controller.
  bit  m_disp;
  int  m_contrast, m_cs, m_ce, m_ps, m_pe, m_col, m_page;
  int  m_op, m_need;
  int  m_args[$];
  wr_t exp_w;
  int  exp_we_cyc = -10;
  int  exp_err_cyc = -10;
  wr_t obs[$];

  int exp_pg[5] = '{6, 6, 7, 7, 6};
  int exp_cl[5] = '{126, 127, 126, 127, 126};

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    m_disp = 1'b0; m_contrast = 'h7F;
    m_cs = 0; m_ce = 127; m_ps = 0; m_pe = 7;
    m_col = 0; m_page = 0;
    m_need = 0; m_op = 0;
    m_args.delete();
  endfunction

  function automatic void model_apply();
    case (m_op)
      'h81: m_contrast = m_args[0];
      'h21: begin m_cs = m_args[0] % 128; m_ce = m_args[1] % 128; m_col = m_cs; end
      'h22: begin m_ps = m_args[0] % 8; m_pe = m_args[1] % 8; m_page = m_ps; end
      default: ;
    endcase
  endfunction

  function automatic void model_byte(input bit dc, input int b);
    if (dc) begin
      exp_w = '{m_page, m_col, b};
      exp_we_cyc = cyc;
      if (m_col == m_ce) begin
        m_col = m_cs;
        m_page = (m_page == m_pe) ? m_ps : (m_page + 1) % 8;
      end else begin
        m_col = (m_col + 1) % 128;
      end
    end else if (m_need > 0) begin
      m_args.push_back(b);
      if (m_args.size() == m_need) begin
        model_apply();
        m_need = 0;
      end
    end else begin
      m_op = b;
      m_args.delete();
      case (b)
        'hAE: m_disp = 1'b0;
        'hAF: m_disp = 1'b1;
        'h81: m_need = 1;
        'h21, 'h22: m_need = 2;
        'h20, 'hD5, 'hA8, 'hD3, 'h8D, 'hDA, 'hD9, 'hDB: m_need = 1;
        default: ;
      endcase
    end
  endfunction

  // Per-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    bit we_exp;
    if (rst_n) begin
      we_exp = (cyc == exp_we_cyc);
      chk("fb_we", bus.fb_we, we_exp);
      if (bus.fb_we) obs.push_back('{int'(bus.fb_page), int'(bus.fb_column), int'(bus.fb_data)});
      if (bus.fb_we && we_exp) begin
        chk("fb_page", bus.fb_page, exp_w.page);
        chk("fb_column", bus.fb_column, exp_w.col);
        chk("fb_data", bus.fb_data, exp_w.data);
      end
      chk("byte_err", bus.byte_err, (cyc == exp_err_cyc));
      chk("display_on", bus.display_on, m_disp);
      chk("contrast", bus.contrast, m_contrast);
    end
  end

  task automatic send_byte(input bit dc, input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      bus.pin_cs = 1'b0; bus.pin_din = b[i]; bus.pin_dc = dc;
      @(posedge clk); #1;
    end
    bus.pin_cs = 1'b1; bus.pin_din = 1'b0;
    @(posedge clk); #1;
    model_byte(dc, b);
  endtask

  task automatic send_partial(input int nbits, input bit dc, input logic [7:0] b);
    for (int i = 0; i < nbits; i++) begin
      bus.pin_cs = 1'b0; bus.pin_din = b[7-i]; bus.pin_dc = dc;
      @(posedge clk); #1;
    end
    bus.pin_cs = 1'b1;
    @(posedge clk); #1;
    exp_err_cyc = cyc;
  endtask

  task automatic pulse_res();
    bus.pin_res = 1'b0;
    @(posedge clk); #1;
    bus.pin_res = 1'b1;
    model_reset();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_fb_we"}, bus.fb_we, 0);
    chk({tag, "_byte_err"}, bus.byte_err, 0);
    chk({tag, "_display_on"}, bus.display_on, 0);
    chk({tag, "_contrast"}, bus.contrast, 'h7F);
    chk({tag, "_fb_page"}, bus.fb_page, 0);
    chk({tag, "_fb_column"}, bus.fb_column, 0);
    chk({tag, "_fb_data"}, bus.fb_data, 0);
  endtask

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    model_reset();
    bus.pin_cs = 1'b1; bus.pin_din = 1'b0; bus.pin_dc = 1'b0; bus.pin_res = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_reset_vals("por");
    rst_n = 1'b1;

    send_byte(0, 8'hAF);
    chk("lit_display_on_AF", bus.display_on, 1);

    send_byte(0, 8'h81);
    send_byte(0, 8'h3C);
    chk("lit_contrast_3C", bus.contrast, 'h3C);
    chk("lit_display_kept", bus.display_on, 1);

    send_byte(0, 8'h21); send_byte(0, 8'h7E); send_byte(0, 8'h7F);
    send_byte(0, 8'h22); send_byte(0, 8'h06); send_byte(0, 8'h07);
    obs.delete();
    for (int i = 0; i < 5; i++) send_byte(1, 8'hA0 + 8'(i));
    @(negedge clk); #1;
    chk("lit_win_count", obs.size(), 5);
    for (int i = 0; i < 5 && i < obs.size(); i++) begin
      chk("lit_win_page", obs[i].page, exp_pg[i]);
      chk("lit_win_col", obs[i].col, exp_cl[i]);
      chk("lit_win_data", obs[i].data, 'hA0 + i);
    end

    // Data interleaved with skipped / pending arguments.
    send_byte(0, 8'h20); send_byte(1, 8'h55); send_byte(0, 8'hAE);
    chk("lit_skip_arg_not_opcode", bus.display_on, 1);
    send_byte(0, 8'hAE);
    chk("lit_display_off", bus.display_on, 0);
    send_byte(0, 8'h81); send_byte(1, 8'h66); send_byte(0, 8'h10);
    chk("lit_contrast_after_data", bus.contrast, 'h10);

    send_partial(5, 1, 8'h99);
    chk("lit_byte_err_pulse", bus.byte_err, 1);
    obs.delete();
    send_byte(1, 8'h5A);
    @(negedge clk); #1;
    chk("lit_after_err_writes", obs.size(), 1);
    if (obs.size() > 0) chk("lit_after_err_data", obs[0].data, 'h5A);

    pulse_res();
    chk("lit_res_contrast", bus.contrast, 'h7F);
    obs.delete();
    for (int i = 0; i < 1024; i++) send_byte(1, 8'(i));
    @(negedge clk); #1;
    chk("lit_full_count", obs.size(), 1024);
    if (obs.size() == 1024) begin
      chk("lit_full_first_pg", obs[0].page, 0);
      chk("lit_full_first_col", obs[0].col, 0);
      chk("lit_full_last_pg", obs[1023].page, 7);
      chk("lit_full_last_col", obs[1023].col, 127);
    end
    send_byte(1, 8'hEE);
    @(negedge clk); #1;
    if (obs.size() == 1025) begin
      chk("lit_wrap_pg", obs[1024].page, 0);
      chk("lit_wrap_col", obs[1024].col, 0);
    end else begin
      chk("lit_wrap_count", obs.size(), 1025);
    end

    // Async reset mid-byte while a contrast argument is pending.
    send_byte(0, 8'hAF);
    send_byte(0, 8'h81);
    for (int i = 0; i < 4; i++) begin
      bus.pin_cs = 1'b0; bus.pin_din = i[0]; bus.pin_dc = 1'b0;
      @(posedge clk); #1;
    end
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check_reset_vals("arst");
    bus.pin_cs = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    send_byte(0, 8'hAE);
    send_byte(0, 8'h81); send_byte(0, 8'h55);
    chk("lit_post_rst_contrast", bus.contrast, 'h55);
    send_byte(0, 8'hAF);
    chk("lit_post_rst_display", bus.display_on, 1);

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
